// File: rtl/spc700_pkg.sv
// Shared types and constants for the SPC700 micro-step sequencer.
// Holds the step-command encoding, the special opcodes and the MUL/DIV extended-phase lengths.
package spc700_pkg;

  typedef enum logic [1:0] {
    NEXT   = 2'd0,
    BRANCH = 2'd1,
    END    = 2'd2,
    EXT    = 2'd3
  } state_ctrl_e;

  localparam logic [7:0] OP_MUL   = 8'hCF;
  localparam logic [7:0] OP_DIV   = 8'h9E;
  localparam logic [7:0] OP_SLEEP = 8'hEF;
  localparam logic [7:0] OP_STOP  = 8'hFF;

  localparam logic [3:0] MUL_EXT = 4'd5;
  localparam logic [3:0] DIV_EXT = 4'd8;

  // Extended-phase step index shown on STATE[1:0]: saturates at 3 while the counter runs on.
  function automatic logic [1:0] ext_step(input logic [3:0] cnt);
    return (cnt > 4'd3) ? 2'd3 : cnt[1:0];
  endfunction

endpackage

// File: rtl/spc700_seq.sv
// SPC700 micro-step sequencer: opcode register, step index, MUL/DIV extended phase and halt.
//
//   state           | meaning
//   ----------------+-------------------------------------------------------------
//   STATE = 0..7    | normal micro-step of the opcode in IR
//   STATE = 8..11   | MUL/DIV extended phase, low bits = min(ext_cnt, 3)
//   HALTED = 1      | SLEEP/STOP finished; IR and STATE frozen until RST
module spc700_seq
  import spc700_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [1:0] STATE_CTRL,
  input  logic       COND,
  input  logic [7:0] DI,
  output logic [7:0] IR,
  output logic [3:0] STATE,
  output logic       SYNC,
  output logic       HALTED
);

  localparam logic [3:0] ST_FETCH = 4'h0;
  localparam logic [3:0] ST_EXT0  = 4'h8;

  state_ctrl_e ctrl;
  logic [3:0]  ext_cnt;
  logic [3:0]  ext_cnt_nxt;
  logic [3:0]  ext_last;
  logic [2:0]  resume_step;
  logic        in_ext;
  logic        muldiv_op;
  logic        halt_op;
  logic        end_step;

  assign ctrl        = state_ctrl_e'(STATE_CTRL);
  assign in_ext      = STATE[3];
  assign muldiv_op   = (IR == OP_MUL) || (IR == OP_DIV);
  assign halt_op     = (IR == OP_SLEEP) || (IR == OP_STOP);
  // A failed branch terminates the instruction exactly like END.
  assign end_step    = (ctrl == END) || ((ctrl == BRANCH) && !COND);
  assign ext_last    = (IR == OP_DIV) ? (DIV_EXT - 4'd1) : (MUL_EXT - 4'd1);
  assign ext_cnt_nxt = ext_cnt + 4'd1;
  assign SYNC        = end_step && !HALTED;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      IR          <= 8'h00;
      STATE       <= ST_FETCH;
      ext_cnt     <= 4'd0;
      resume_step <= 3'd0;
      HALTED      <= 1'b0;
    end else if (EN && !HALTED) begin
      if (in_ext) begin
        // Step commands are ignored here; only the counter decides when to resume.
        if (ext_cnt == ext_last) begin
          STATE   <= {1'b0, resume_step};
          ext_cnt <= 4'd0;
        end else begin
          ext_cnt <= ext_cnt_nxt;
          STATE   <= {2'b10, ext_step(ext_cnt_nxt)};
        end
      end else if (end_step) begin
        STATE <= ST_FETCH;
        if (halt_op) begin
          HALTED <= 1'b1;
        end else begin
          IR <= DI;
        end
      end else if ((ctrl == EXT) && muldiv_op) begin
        STATE       <= ST_EXT0;
        ext_cnt     <= 4'd0;
        resume_step <= STATE[2:0] + 3'd1;
      end else begin
        STATE <= {1'b0, STATE[2:0] + 3'd1};
      end
    end
  end

endmodule

// File: tb/tb_spc700_seq.sv
// Self-checking bench for spc700_seq: directed vectors plus a behavioural model checked every cycle.
module tb_spc700_seq;
  import spc700_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [1:0] STATE_CTRL;
  logic       COND;
  logic [7:0] DI;
  logic [7:0] IR;
  logic [3:0] STATE;
  logic       SYNC;
  logic       HALTED;

  int n_checks = 0;
  int n_errors = 0;

  // model of the architectural state
  int m_ir, m_state, m_halted, m_ext_left, m_ext_seen, m_resume;
  logic last_sync;

  spc700_seq dut (
    .CLK(CLK), .RST(RST), .EN(EN), .STATE_CTRL(STATE_CTRL), .COND(COND),
    .DI(DI), .IR(IR), .STATE(STATE), .SYNC(SYNC), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_ir = 0; m_state = 0; m_halted = 0; m_ext_left = 0; m_ext_seen = 0; m_resume = 0;
  endfunction

  function automatic void model_step(input bit en, input int ctrl, input bit cond, input int di);
    int op;
    if (!en || m_halted != 0) return;
    if (m_ext_left > 0) begin
      m_ext_left--;
      m_ext_seen++;
      m_state = (m_ext_left == 0) ? m_resume : 8 + ((m_ext_seen > 3) ? 3 : m_ext_seen);
      return;
    end
    op = ctrl;
    if (op == 1) op = cond ? 0 : 2;
    if (op == 3 && m_ir != 'hCF && m_ir != 'h9E) op = 0;
    case (op)
      2: begin
        if (m_ir == 'hEF || m_ir == 'hFF) m_halted = 1;
        else m_ir = di;
        m_state = 0;
      end
      3: begin
        m_ext_left = (m_ir == 'hCF) ? 5 : 8;
        m_ext_seen = 0;
        m_resume   = (m_state + 1) % 8;
        m_state    = 8;
      end
      default: m_state = (m_state + 1) % 8;
    endcase
  endfunction

  function automatic int model_sync();
    if (m_halted != 0) return 0;
    return (STATE_CTRL == 2'd2 || (STATE_CTRL == 2'd1 && !COND)) ? 1 : 0;
  endfunction

  // Per-cycle comparison against the model, mid low phase.
  always @(negedge CLK) begin
    #2;
    if (!RST) begin
      chk("ir", int'(IR), m_ir);
      chk("state", int'(STATE), m_state);
      chk("halted", int'(HALTED), m_halted);
      chk("sync", int'(SYNC), model_sync());
    end
  end

  task automatic step(input bit en, input logic [1:0] ctrl, input bit cond, input logic [7:0] di);
    @(negedge CLK);
    EN = en; STATE_CTRL = ctrl; COND = cond; DI = di;
    #1 last_sync = SYNC;
    @(posedge CLK);
    model_step(en, int'(ctrl), cond, int'(di));
    #1 EN = 1'b0;
  endtask

  task automatic run_ext(input bit rand_en, output int seq[$], output int en_steps);
    int guard;
    bit en;
    seq = {};
    step(1'b1, EXT, 1'b0, 8'h00);
    en_steps = 1;
    seq.push_back(int'(STATE));
    guard = 0;
    while (STATE[3] && guard < 100) begin
      en = rand_en ? bit'($urandom_range(0, 1)) : 1'b1;
      step(en, 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 8'h77);
      if (en) begin
        en_steps++;
        seq.push_back(int'(STATE));
      end
      guard++;
    end
    chk("ext_timeout", int'(STATE[3]), 0);
  endtask

  task automatic check_seq(input string name, input int got[$], input int exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
  endtask

  task automatic async_reset();
    #1 RST = 1'b1;
    #1;
    chk("rst_ir", int'(IR), 0);
    chk("rst_state", int'(STATE), 0);
    chk("rst_halted", int'(HALTED), 0);
    model_reset();
    #1 RST = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[$];
    int mul_exp[$];
    int div_exp[$];
    int n;
    mul_exp = '{8, 9, 10, 11, 11, 3};
    div_exp = '{8, 9, 10, 11, 11, 11, 11, 11, 3};

    RST = 1'b1; EN = 1'b0; STATE_CTRL = 2'd0; COND = 1'b0; DI = 8'h00; last_sync = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_ir", int'(IR), 0);
    chk("reset_state", int'(STATE), 0);
    chk("reset_halted", int'(HALTED), 0);
    @(negedge CLK);
    RST = 1'b0;

    // NOP from reset ends with a fetch of 0xE8
    step(1'b1, END, 1'b0, 8'hE8);
    chk("fetch_sync", int'(last_sync), 1);
    chk("fetch_ir", int'(IR), 'hE8);
    chk("fetch_state", int'(STATE), 0);
    step(1'b1, NEXT, 1'b0, 8'h00);
    chk("next_state", int'(STATE), 1);

    // EN=0 freezes everything
    repeat (3) step(1'b0, END, 1'b0, 8'h55);
    chk("en0_ir", int'(IR), 'hE8);
    chk("en0_state", int'(STATE), 1);

    // failed branch fetches, taken branch advances
    step(1'b1, END, 1'b0, 8'hF0);
    step(1'b1, NEXT, 1'b0, 8'h00);
    step(1'b1, BRANCH, 1'b0, 8'h12);
    chk("brf_sync", int'(last_sync), 1);
    chk("brf_ir", int'(IR), 'h12);
    chk("brf_state", int'(STATE), 0);
    step(1'b1, END, 1'b0, 8'hF0);
    step(1'b1, NEXT, 1'b0, 8'h00);
    step(1'b1, BRANCH, 1'b1, 8'h34);
    chk("brt_sync", int'(last_sync), 0);
    chk("brt_ir", int'(IR), 'hF0);
    chk("brt_state", int'(STATE), 2);

    // wrap 7 -> 0 without a fetch, then EXT on a plain opcode acts as NEXT
    repeat (5) step(1'b1, NEXT, 1'b0, 8'h99);
    chk("pre_wrap_state", int'(STATE), 7);
    step(1'b1, NEXT, 1'b0, 8'h99);
    chk("wrap_state", int'(STATE), 0);
    chk("wrap_ir", int'(IR), 'hF0);
    step(1'b1, EXT, 1'b0, 8'h99);
    chk("ext_plain_state", int'(STATE), 1);

    // MUL
    step(1'b1, END, 1'b0, OP_MUL);
    step(1'b1, NEXT, 1'b0, 8'h00);
    step(1'b1, NEXT, 1'b0, 8'h00);
    run_ext(1'b0, seq, n);
    check_seq("mul_seq", seq, mul_exp);
    step(1'b1, END, 1'b0, OP_DIV);
    chk("mul_cycles", 2 + n + 1, 9);

    // DIV, EN held high
    step(1'b1, NEXT, 1'b0, 8'h00);
    step(1'b1, NEXT, 1'b0, 8'h00);
    run_ext(1'b0, seq, n);
    check_seq("div_seq", seq, div_exp);
    step(1'b1, END, 1'b0, OP_DIV);
    chk("div_cycles", 2 + n + 1, 12);

    // DIV with random EN gaps
    step(1'b1, NEXT, 1'b0, 8'h00);
    step(1'b1, NEXT, 1'b0, 8'h00);
    run_ext(1'b1, seq, n);
    check_seq("div_rand_seq", seq, div_exp);

    // reset mid-DIV at STATE=10
    step(1'b1, END, 1'b0, OP_DIV);
    step(1'b1, NEXT, 1'b0, 8'h00);
    step(1'b1, NEXT, 1'b0, 8'h00);
    step(1'b1, EXT, 1'b0, 8'h00);
    step(1'b1, NEXT, 1'b0, 8'h00);
    step(1'b1, NEXT, 1'b0, 8'h00);
    chk("div_mid_state", int'(STATE), 10);
    async_reset();
    step(1'b1, NEXT, 1'b0, 8'h00);
    chk("post_rst_state", int'(STATE), 1);
    chk("post_rst_ir", int'(IR), 0);

    // STOP halts at its own END
    step(1'b1, END, 1'b0, OP_STOP);
    step(1'b1, NEXT, 1'b0, 8'h00);
    chk("stop_running", int'(HALTED), 0);
    step(1'b1, END, 1'b0, 8'h33);
    chk("stop_halted", int'(HALTED), 1);
    chk("stop_ir", int'(IR), 'hFF);
    chk("stop_state", int'(STATE), 0);
    for (int i = 0; i < 100; i++)
      step(1'b1, 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    chk("halt_hold_ir", int'(IR), 'hFF);
    chk("halt_hold_state", int'(STATE), 0);
    chk("halt_hold_halted", int'(HALTED), 1);
    chk("halt_sync", int'(last_sync), 0);
    async_reset();

    // SLEEP halts the same way
    step(1'b1, END, 1'b0, OP_SLEEP);
    step(1'b1, END, 1'b0, 8'h44);
    chk("sleep_halted", int'(HALTED), 1);
    chk("sleep_ir", int'(IR), 'hEF);
    async_reset();
    step(1'b1, END, 1'b0, 8'h21);
    chk("final_ir", int'(IR), 'h21);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
